// File: rtl/pulse_scheduler.sv
// Round-robin front end for a shared pulse_generator: loads a requester's pattern,
// lets it rotate for WIDTH x repeat clocks, then flushes it with zeros and reports completion.
module pulse_scheduler #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_pattern,
  input  logic [CNT_W-1:0] req0_repeat,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_pattern,
  input  logic [CNT_W-1:0] req1_repeat,
  output logic             req1_ready,
  output logic [WIDTH-1:0] gen_in,
  output logic             gen_load,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             done_id
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] rep_q;

  logic             idle;
  logic             winner;
  logic             accept;
  logic             bit_wrap;
  logic             run_last;
  logic [CNT_W-1:0] sel_repeat;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    idle       = (state == S_IDLE);
    winner     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = reset && idle && req0_valid && !winner;
    req1_ready = reset && idle && req1_valid && winner;
    accept     = req0_ready || req1_ready;
    sel_repeat = winner ? req1_repeat : req0_repeat;
    bit_wrap   = (bit_cnt == BIT_LAST);
    run_last   = bit_wrap && (rep_cnt == rep_q - CNT_W'(1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            grant_q    <= winner;
            last_grant <= winner;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          bit_cnt <= '0;
          rep_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (run_last) begin
            state <= S_DONE;
          end else if (bit_wrap) begin
            bit_cnt <= '0;
            rep_cnt <= rep_cnt + CNT_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Job data only matters once a job is accepted, so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      pat_q <= winner ? req1_pattern : req0_pattern;
      rep_q <= (sel_repeat == '0) ? CNT_W'(1) : sel_repeat;
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    gen_load = (state == S_LOAD) || (state == S_DONE);
    gen_in   = ((state == S_LOAD) || (state == S_RUN)) ? pat_q : '0;
    done     = (state == S_DONE);
    done_id  = done && grant_q;
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: offset-based job model checked every cycle,
// directed scenarios with literal expectations, and a behavioural generator.
module tb_pulse_scheduler;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_pattern, req1_pattern;
  logic [CNT_W-1:0] req0_repeat, req1_repeat;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] gen_in;
  logic             gen_load, busy, grant_id, done, done_id;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic             m_active = 1'b0;
  logic             m_last   = 1'b1;
  logic             m_id     = 1'b0;
  int               m_acc    = 0;
  int               m_rep    = 1;
  logic [WIDTH-1:0] m_pat    = '0;

  logic [WIDTH-1:0] greg = '0;
  logic             gen_o = 1'b0;

  pulse_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_pattern(req0_pattern), .req0_repeat(req0_repeat),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pattern(req1_pattern), .req1_repeat(req1_repeat),
    .req1_ready(req1_ready),
    .gen_in(gen_in), .gen_load(gen_load), .busy(busy), .grant_id(grant_id),
    .done(done), .done_id(done_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream pulse_generator: load or rotate left, output registered MSB.
  always @(posedge clock) begin
    if (gen_load) greg <= gen_in;
    else          greg <= {greg[WIDTH-2:0], greg[WIDTH-1]};
    gen_o <= greg[WIDTH-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs from the job's offset since acceptance.
  task automatic model_check();
    int   off;
    int   runlen;
    logic ph_load, ph_done, have_w, w;
    off = 0;
    runlen = 0;
    cyc++;
    if (!reset) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gen_load", 32'(gen_load), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_gen_in", 32'(gen_in), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_done_id", 32'(done_id), 32'd0);
      m_active = 1'b0;
      m_last   = 1'b1;
      return;
    end
    if (m_active) begin
      off    = cyc - m_acc;
      runlen = WIDTH * m_rep;
      if (off > runlen + 2) m_active = 1'b0;
    end
    ph_load = m_active && (off == 1);
    ph_done = m_active && (off == runlen + 2);
    have_w  = !m_active && (req0_valid || req1_valid);
    w       = (req0_valid && req1_valid) ? !m_last : req1_valid;
    chk("busy", 32'(busy), 32'(m_active));
    chk("gen_load", 32'(gen_load), 32'(ph_load || ph_done));
    chk("done", 32'(done), 32'(ph_done));
    chk("req0_ready", 32'(req0_ready), 32'(have_w && !w));
    chk("req1_ready", 32'(req1_ready), 32'(have_w && w));
    if (m_active) begin
      chk("gen_in", 32'(gen_in), ph_done ? 32'd0 : 32'(m_pat));
      chk("grant_id", 32'(grant_id), 32'(m_id));
    end
    if (ph_done) chk("done_id", 32'(done_id), 32'(m_id));
    if (have_w) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_id     = w;
      m_last   = w;
      m_pat    = w ? req1_pattern : req0_pattern;
      m_rep    = int'(w ? req1_repeat : req0_repeat);
      if (m_rep == 0) m_rep = 1;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_check();
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic run_until_done(input int limit, output int n, output logic id,
                                output logic ld, output logic [WIDTH-1:0] gi);
    n = 0; id = 1'b0; ld = 1'b0; gi = '0;
    for (int i = 0; i < limit; i++) begin
      sample();
      n++;
      if (done === 1'b1) begin
        id = done_id; ld = gen_load; gi = gen_in;
        advance();
        return;
      end
      advance();
    end
    chk("done_timeout", 32'd0, 32'd1);
    n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int               n;
    logic             id, ld, seen;
    logic [WIDTH-1:0] gi, bits;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_pattern = '0; req1_pattern = '0;
    req0_repeat = '0;  req1_repeat = '0;

    // Reset state, then a single job from requester 0.
    sample();
    chk("t0_busy_reset", 32'(busy), 32'd0);
    advance();
    reset = 1'b1;
    req0_valid = 1'b1; req0_pattern = 16'hA5F0; req0_repeat = 8'd2;
    sample();
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    advance();
    req0_valid = 1'b0;
    sample();
    chk("t1_load", 32'(gen_load), 32'd1);
    chk("t1_gen_in", 32'(gen_in), 32'hA5F0);
    chk("t1_grant", 32'(grant_id), 32'd0);
    advance();
    run_until_done(100, n, id, ld, gi);
    chk("t1_run_plus_done", 32'(n), 32'd33);
    chk("t1_done_id", 32'(id), 32'd0);
    chk("t1_flush_load", 32'(ld), 32'd1);
    chk("t1_flush_in", 32'(gi), 32'd0);
    sample();
    chk("t1_busy_after", 32'(busy), 32'd0);
    advance();

    // Tie after reset: grants alternate 0, 1, 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_pattern = 16'h1234; req0_repeat = 8'd1;
    req1_valid = 1'b1; req1_pattern = 16'h5678; req1_repeat = 8'd1;
    for (int j = 0; j < 3; j++) begin
      sample();
      chk("t2_grant_order", 32'({req1_ready, req0_ready}), (j == 1) ? 32'd2 : 32'd1);
      advance();
      run_until_done(60, n, id, ld, gi);
      chk("t2_job_span", 32'(n + 1), 32'd19);
      chk("t2_done_id", 32'(id), (j == 1) ? 32'd1 : 32'd0);
    end

    // Repeat zero behaves as one rotation.
    req0_valid = 1'b0;
    req1_pattern = 16'hFFFF; req1_repeat = 8'd0;
    sample();
    chk("t3_ready1", 32'(req1_ready), 32'd1);
    advance();
    req1_valid = 1'b0;
    run_until_done(60, n, id, ld, gi);
    chk("t3_len", 32'(n), 32'd18);
    chk("t3_done_id", 32'(id), 32'd1);

    // Request arriving mid-job waits for the first idle cycle.
    req0_valid = 1'b1; req0_pattern = 16'h00FF; req0_repeat = 8'd1;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    req1_valid = 1'b1; req1_pattern = 16'h0F0F; req1_repeat = 8'd2;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      sample();
      chk("t4_blocked", 32'(req1_ready), 32'd0);
      seen = done;
      advance();
    end
    chk("t4_done_seen", 32'(seen), 32'd1);
    sample();
    chk("t4_ready_idle", 32'(req1_ready), 32'd1);
    advance();
    req1_valid = 1'b0;
    run_until_done(100, n, id, ld, gi);
    chk("t4_len", 32'(n), 32'd34);
    chk("t4_done_id", 32'(id), 32'd1);

    // Asynchronous reset in the middle of RUN.
    req0_valid = 1'b1; req0_pattern = 16'hAAAA; req0_repeat = 8'd3;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    req0_valid = 1'b1; req0_pattern = 16'h1111; req0_repeat = 8'd1;
    req1_valid = 1'b1; req1_pattern = 16'h2222; req1_repeat = 8'd1;
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_gen_load", 32'(gen_load), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_readys", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    reset = 1'b1;
    sample();
    chk("t5_first_grant0", 32'(req0_ready), 32'd1);
    chk("t5_first_grant1", 32'(req1_ready), 32'd0);
    advance();
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_until_done(60, n, id, ld, gi);
    chk("t5_done_id", 32'(id), 32'd0);

    // Serial output through the generator model.
    req0_valid = 1'b1; req0_pattern = 16'h8001; req0_repeat = 8'd1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sample();
      bits = {bits[WIDTH-2:0], gen_o};
      advance();
    end
    chk("t6_serial", 32'(bits), 32'h8001);
    tick();
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t6_silent", 32'(gen_o), 32'd0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Round-robin controller that shares one 16-bit pulse_generator between two requesters.
- Accepts a pattern and repeat count from a requester, loads the pattern into the generator, and lets it rotate for WIDTH×repeat clocks.
- Then flushes the generator with zeros and reports completion.
- Sits directly in front of pulse_generator: drives its in and load_flag; shares its clock.

Parameters:
WIDTH, 16, pattern width; equals the generator register width.
CNT_W, 8, width of the repeat count.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a job
req0_pattern  input  WIDTH  requester 0 pattern
req0_repeat  input  CNT_W  requester 0 number of full rotations
req0_ready  output  1  requester 0 job accepted this cycle
req1_valid  input  1  requester 1 has a job
req1_pattern  input  WIDTH  requester 1 pattern
req1_repeat  input  CNT_W  requester 1 number of full rotations
req1_ready  output  1  requester 1 job accepted this cycle
gen_in  output  WIDTH  to pulse_generator in
gen_load  output  1  to pulse_generator load_flag
busy  output  1  job in progress (LOAD, RUN, DONE)
grant_id  output  1  requester owning the generator; valid while busy
done  output  1  one-cycle completion pulse
done_id  output  1  requester whose job completed; valid with done

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all outputs = 0; bit and repeat counters = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Takes effect immediately, including mid-RUN. The generator has no reset and is not flushed; its next load overwrites it.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: high only for the arbitration winner, only in IDLE.
  - Winner when only one valid: that requester.
  - Winner when both valid: the requester not equal to last_grant.
  - On valid&ready: latch pattern; latch repeat (repeat=0 is latched as 1); set grant_id and last_grant; go to LOAD.
  - gen_load = 0 in IDLE.
- LOAD (1 cycle): gen_in = latched pattern, gen_load = 1, busy = 1. Go to RUN; bit counter = 0, repeat counter = 0.
- RUN:
  - gen_load = 0; gen_in holds the latched pattern.
  - Bit counter increments 0..WIDTH-1 and wraps. On wrap, the repeat counter increments.
  - Leave RUN after exactly WIDTH×repeat cycles: bit counter = WIDTH-1 and repeat counter = repeat-1 → DONE.
- DONE (1 cycle):
  - gen_in = 0 and gen_load = 1, flushing the generator so its output goes silent.
  - done = 1; done_id = grant_id.
  - Go to IDLE.
- busy = 1 in LOAD, RUN and DONE.
- Job timing: accept cycle + 1 LOAD + WIDTH×repeat RUN + 1 DONE. Minimum gap between jobs is one IDLE cycle.
- Requests arriving while busy: ready stays 0. The requester must hold valid; it is arbitrated in the first IDLE cycle.
- Requester data only needs to be stable in the accept cycle. Dropping valid before acceptance is legal.
- Generator serial order (downstream consequence, not checked by this block): o emits pattern[15] first, then [14] … [0], repeating. o lags the internal register by one clock.
- Counter widths: bit counter is ceil(log2(WIDTH)) bits; repeat counter is CNT_W bits. Maximum RUN length is WIDTH×(2^CNT_W−1) = 4080 cycles at the defaults, with no overflow.

Test Plan:
1. Single job: req0 pattern 16'hA5F0, repeat 2, req1 idle.
   - req0_ready=1 in the accept cycle.
   - Next cycle: gen_load=1, gen_in=16'hA5F0, busy=1, grant_id=0.
   - Then exactly 32 cycles with gen_load=0.
   - Then done=1, done_id=0, gen_load=1, gen_in=0.
   - Next cycle: busy=0.
2. Tie after reset: both valid continuously, repeat 1.
   - Grants in order 0, 1, 0.
   - done_id sequence 0, 1, 0.
   - Each job spans 19 cycles: accept, LOAD, 16 RUN, DONE.
3. Repeat zero: req1 pattern 16'hFFFF, repeat 0 → exactly 16 RUN cycles, then done=1, done_id=1.
4. Blocked request: req1_valid rises mid-RUN of a req0 job.
   - req1_ready stays 0 through DONE.
   - req1_ready=1 in the first IDLE cycle after DONE.
5. Reset mid-RUN: assert reset=0 at RUN cycle 5 (off clock edge).
   - busy, gen_load, done, both readys drop to 0 immediately.
   - After release with req0 and req1 both valid, req0 is granted first.
6. Integration with pulse_generator: req0 pattern 16'h8001, repeat 1.
   - Generator o produces 1, 0×14, 1.
   - After the DONE flush, o stays 0.
